// File: rtl/ata_pkg.sv
// ata_pkg: shared phase/lamp encodings and index helper for adaptive_traffic_arbiter_n.
package ata_pkg;
  localparam logic [1:0] PH_GREEN  = 2'b00;
  localparam logic [1:0] PH_AMBER  = 2'b01;
  localparam logic [1:0] PH_ALLRED = 2'b10;
  localparam logic [2:0] LAMP_GREEN = 3'b001;
  localparam logic [2:0] LAMP_AMBER = 3'b010;
  localparam logic [2:0] LAMP_RED   = 3'b100;
  function automatic int inc_mod(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction
endpackage

// File: rtl/ata_next_sel.sv
// ata_next_sel: picks the highest-demand other approach, ties to the first in round-robin order.
module ata_next_sel
  import ata_pkg::*;
#(
  parameter int N_WAY  = 4,
  parameter int SENS_W = 2
) (
  input  logic [N_WAY*SENS_W-1:0]   sens,
  input  logic [$clog2(N_WAY)-1:0]  active_idx,
  output logic [$clog2(N_WAY)-1:0]  next_idx,
  output logic [SENS_W-1:0]         max_other
);
  localparam int IW = $clog2(N_WAY);
  always_comb begin
    logic [IW-1:0] j;
    j = IW'(inc_mod(int'(active_idx), N_WAY));
    next_idx = j;
    max_other = '0;
    for (int k = 1; k < N_WAY; k++) begin
      if (sens[j*SENS_W +: SENS_W] > max_other) begin
        max_other = sens[j*SENS_W +: SENS_W];
        next_idx = j;
      end
      j = IW'(inc_mod(int'(j), N_WAY));
    end
  end
endmodule

// File: rtl/adaptive_traffic_arbiter_n.sv
// adaptive_traffic_arbiter_n: N-way green/amber/all-red controller with demand-driven selection.
// Optional emergency preemption enabled by defining ATA_EMERG_PREEMPT_EN.
module adaptive_traffic_arbiter_n
  import ata_pkg::*;
#(
  parameter int N_WAY       = 4,
  parameter int SENS_W      = 2,
  parameter int CNT_W       = 6,
  parameter int GREEN_TIME  = 30,
  parameter int AMBER_TIME  = 3,
  parameter int ALLRED_TIME = 1,
  parameter int MAX_EXT     = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tick,
  input  logic [N_WAY*SENS_W-1:0]   sens,
`ifdef ATA_EMERG_PREEMPT_EN
  input  logic                      emerg_req,
  input  logic [$clog2(N_WAY)-1:0]  emerg_idx,
`endif
  output logic [3*N_WAY-1:0]        lights,
  output logic [1:0]                phase,
  output logic [$clog2(N_WAY)-1:0]  active_idx,
  output logic [CNT_W-1:0]          timer,
  output logic                      phase_start
);
  localparam int IW = $clog2(N_WAY);
  localparam int EW = $clog2(MAX_EXT + 2);
  logic [1:0] phase_d, phase_q;
  logic [IW-1:0] active_d, active_q, next_d, next_q, sel_idx, emerg_tgt;
  logic [CNT_W-1:0] timer_d, timer_q;
  logic [EW-1:0] ext_d, ext_q;
  logic [3*N_WAY-1:0] lights_d, lights_q;
  logic phase_start_d, phase_start_q;
  logic [SENS_W-1:0] max_other, cur_sens;
  logic expire, preempt, hold;
  ata_next_sel #(.N_WAY(N_WAY), .SENS_W(SENS_W)) u_sel (
    .sens(sens), .active_idx(active_q), .next_idx(sel_idx), .max_other(max_other)
  );
`ifdef ATA_EMERG_PREEMPT_EN
  assign preempt   = emerg_req && emerg_idx != active_q;
  assign hold      = emerg_req && emerg_idx == active_q;
  assign emerg_tgt = emerg_idx;
`else
  assign preempt   = 1'b0;
  assign hold      = 1'b0;
  assign emerg_tgt = '0;
`endif
  assign cur_sens = sens[active_q*SENS_W +: SENS_W];
  assign expire   = tick && timer_q == '0;
  always_comb begin
    phase_d  = phase_q;
    active_d = active_q;
    next_d   = next_q;
    ext_d    = ext_q;
    timer_d  = (tick && timer_q != '0) ? timer_q - CNT_W'(1) : timer_q;
    case (phase_q)
      PH_GREEN:
        if (preempt) begin
          phase_d = PH_AMBER;
          timer_d = CNT_W'(AMBER_TIME - 1);
        end else if (expire) begin
          timer_d = CNT_W'(GREEN_TIME - 1);
          // Extend only while this approach strictly dominates and the cap allows it
          if (!hold && max_other != '0) begin
            if (cur_sens > max_other && ext_q < EW'(MAX_EXT)) ext_d = ext_q + EW'(1);
            else begin
              phase_d = PH_AMBER;
              timer_d = CNT_W'(AMBER_TIME - 1);
            end
          end
        end
      PH_AMBER:
        if (expire) begin
          phase_d = PH_ALLRED;
          timer_d = CNT_W'(ALLRED_TIME - 1);
          next_d  = preempt ? emerg_tgt : sel_idx;
        end
      PH_ALLRED:
        if (expire) begin
          phase_d  = PH_GREEN;
          active_d = next_q;
          timer_d  = CNT_W'(GREEN_TIME - 1);
          ext_d    = '0;
        end
      default: begin
        phase_d = PH_GREEN;
        timer_d = CNT_W'(GREEN_TIME - 1);
      end
    endcase
    for (int i = 0; i < N_WAY; i++)
      lights_d[i*3 +: 3] = (IW'(i) != active_d || phase_d == PH_ALLRED) ? LAMP_RED :
                           (phase_d == PH_AMBER) ? LAMP_AMBER : LAMP_GREEN;
    phase_start_d = phase_d != phase_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q       <= PH_GREEN;
      active_q      <= '0;
      next_q        <= '0;
      timer_q       <= CNT_W'(GREEN_TIME - 1);
      ext_q         <= '0;
      lights_q      <= {{(N_WAY-1){LAMP_RED}}, LAMP_GREEN};
      phase_start_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      active_q      <= active_d;
      next_q        <= next_d;
      timer_q       <= timer_d;
      ext_q         <= ext_d;
      lights_q      <= lights_d;
      phase_start_q <= phase_start_d;
    end
  end
  assign lights      = lights_q;
  assign phase       = phase_q;
  assign active_idx  = active_q;
  assign timer       = timer_q;
  assign phase_start = phase_start_q;
endmodule

// File: doc/adaptive_traffic_arbiter_n.md
Name: adaptive_traffic_arbiter_n

Overview:
Parametrised successor to the fixed 4-way adaptive traffic controller. It serves N_WAY approaches with a green → amber → all-red cycle, and selects the next green from sensor demand with round-robin tie-breaking. Phase durations are timed by an internal countdown driven by an external 1-per-second `tick` enable, so no external counter is needed. Green extensions are capped to prevent starvation. It sits between the sensor front-end and the lamp drivers.

Parameters:
- N_WAY, 4, number of approaches (2..8).
- SENS_W, 2, width of each approach's demand level.
- CNT_W, 6, timer width; must hold GREEN_TIME-1.
- GREEN_TIME, 30, ticks per green slot.
- AMBER_TIME, 3, ticks of amber.
- ALLRED_TIME, 1, ticks of all-red clearance.
- MAX_EXT, 2, maximum consecutive green extensions.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, synchronous active-low reset.
- tick, in, 1, one-cycle timing enable; the timer only moves on tick.
- sens, in, N_WAY*SENS_W, packed demand levels; approach i is at [i*SENS_W +: SENS_W].
- lights, out, 3*N_WAY, per approach [i*3 +: 3]: 001 green, 010 amber, 100 red.
- phase, out, 2, 00 GREEN, 01 AMBER, 10 ALLRED.
- active_idx, out, $clog2(N_WAY), approach currently being served.
- timer, out, CNT_W, ticks remaining in the current phase minus 1.
- phase_start, out, 1, one-cycle pulse on the cycle after any phase change.

Behaviour:
- All state and outputs are registered; outputs are a Moore function of state and are never driven from `sens`.
- Reset applies on the rising edge of clk while rst_n=0, including mid-phase. Reset values:
  - phase = GREEN, active_idx = 0, timer = GREEN_TIME-1, ext_cnt = 0.
  - lights = approach 0 green, all others red.
  - phase_start = 0.
- Timer:
  - On entry to a phase, timer loads duration-1.
  - On a tick with timer ≠ 0, timer decrements.
  - A phase ends on a tick with timer == 0, so each phase lasts exactly its duration in ticks.
  - With tick=0 all state holds.
- GREEN end decision, taken on the expiring tick (sens sampled that cycle):
  - All other approaches have sens = 0: reload GREEN_TIME-1; ext_cnt unchanged.
  - Else, current sens is strictly greater than every other sens and ext_cnt < MAX_EXT: reload and increment ext_cnt.
  - Else: go to AMBER.
- AMBER: when it expires, go to ALLRED and latch next_idx in the same cycle.
- ALLRED: when it expires, go to GREEN with active_idx = next_idx and ext_cnt = 0.
- next_idx selection:
  - Choose the maximum sens among j ≠ active_idx.
  - Ties go to the first candidate in the scan order active_idx+1, active_idx+2, … (mod N_WAY).
  - If all candidates are 0, choose active_idx+1 (mod N_WAY).
  - The current approach is never re-selected.
- Lamps:
  - In AMBER, only active_idx shows amber.
  - In ALLRED, every approach shows red.
  - At most one approach is ever non-red.
- Arithmetic: index wrap is mod N_WAY and must be correct for non-power-of-2 N_WAY. Sensor comparisons are unsigned.

Optional Feature:
- Macro: ATA_EMERG_PREEMPT_EN.
- When defined, two extra inputs are added: emerg_req (1 bit) and emerg_idx ($clog2(N_WAY) bits).
- While emerg_req=1 and emerg_idx ≠ active_idx:
  - A GREEN phase jumps to AMBER on the next cycle, without waiting for tick.
  - The following ALLRED latches next_idx = emerg_idx.
- While emerg_req=1 and emerg_idx = active_idx in GREEN, the timer reloads on every expiry and extension limits are ignored.
- When undefined, the ports do not exist and behaviour is exactly as above.

Decomposition:
- Package ata_pkg holds:
  - The phase encoding localparams.
  - The lamp code constants: GREEN 3'b001, AMBER 3'b010, RED 3'b100.
  - The function for index increment mod N.
- One natural sub-module, ata_next_sel: a combinational max-with-round-robin-tie selector taking sens and active_idx and producing next_idx. The FSM, timer and lamp decode stay in the top.

Test Plan:
- Reset, tick every cycle, sens all 0 for 200 cycles → stays GREEN on approach 0; timer reloads every 30 ticks; lights = approach 0 green.
- sens0=0, sens2=3, others 0 → at tick 30, AMBER on 0 for 3 ticks; ALLRED for 1 tick; then GREEN on 2 with phase_start pulsing at each change.
- sens0=3, others 1, MAX_EXT=2 → green on 0 lasts 90 ticks, then AMBER; next green is approach 1 (tie, round-robin from 1).
- active=2, sens1=sens3=2, sens0=1 → next_idx = 3.
- rst_n=0 for one cycle during AMBER of approach 3 → next cycle: GREEN, active_idx 0, timer 29; tick gaps of 5 cycles stretch phases 5× with no skipped ticks.
- ATA_EMERG_PREEMPT_EN: green on 0, emerg_req=1, emerg_idx=2 mid-green → AMBER the next cycle, then ALLRED, then GREEN on 2, held while emerg_req=1.
